// File: rtl/cam_ctrl.sv
// Command sequencer and round-robin two-port arbiter in front of a block-RAM CAM.
// Optional occupancy counter and full flag: define CAM_CTRL_OCCUPANCY_EN.
module cam_ctrl #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 5,
  parameter int LOOKUP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_op,
  input  logic [DATA_WIDTH-1:0] req0_key,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_op,
  input  logic [DATA_WIDTH-1:0] req1_key,
  output logic                  rsp_valid,
  output logic                  rsp_port,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  input  logic                  cam_match,
  output logic                  busy
`ifdef CAM_CTRL_OCCUPANCY_EN
  ,
  output logic [ADDR_WIDTH:0]   used_count,
  output logic                  full
`endif
);

  localparam int SLOTS = 2**ADDR_WIDTH;
  localparam int CW    = (LOOKUP_LATENCY > 1) ? $clog2(LOOKUP_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_DECIDE, S_WRITE, S_WAIT, S_RESP
  } state_t;

  state_t                  state, state_nx;
  logic [SLOTS-1:0]        bitmap;
  logic                    rr, port_q, op_q, wait_first;
  logic [DATA_WIDTH-1:0]   key_q;
  logic [ADDR_WIDTH-1:0]   waddr_q, rsp_addr_q, free_addr;
  logic [1:0]              rsp_status_q;
  logic [CW-1:0]           lat_cnt;
  logic                    gnt_vld, gnt_port, gnt_op, has_free;
  logic [DATA_WIDTH-1:0]   gnt_key;

  // rr holds the port that wins the next tie
  assign gnt_vld    = (state == S_IDLE) && (req0_valid || req1_valid);
  assign gnt_port   = (req0_valid && req1_valid) ? rr : req1_valid;
  assign gnt_op     = gnt_port ? req1_op  : req0_op;
  assign gnt_key    = gnt_port ? req1_key : req0_key;
  assign req0_ready = gnt_vld && !gnt_port;
  assign req1_ready = gnt_vld &&  gnt_port;

  assign has_free = ~&bitmap;
  always_comb begin
    free_addr = '0;
    for (int i = SLOTS-1; i >= 0; i--)
      if (!bitmap[i]) free_addr = ADDR_WIDTH'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:   if (!cam_write_busy) state_nx = S_IDLE;
      S_IDLE:   if (gnt_vld) state_nx = S_LOOKUP;
      S_LOOKUP: if (lat_cnt == CW'(LOOKUP_LATENCY-1)) state_nx = S_DECIDE;
      S_DECIDE: state_nx = ((!op_q && !cam_match && has_free) || (op_q && cam_match))
                           ? S_WRITE : S_RESP;
      S_WRITE:  state_nx = S_WAIT;
      S_WAIT:   if (!wait_first && !cam_write_busy) state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap       <= '0;
      rr           <= 1'b0;
      port_q       <= 1'b0;
      op_q         <= 1'b0;
      key_q        <= '0;
      waddr_q      <= '0;
      rsp_addr_q   <= '0;
      rsp_status_q <= 2'b00;
      lat_cnt      <= '0;
      wait_first   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (gnt_vld) begin
          port_q  <= gnt_port;
          op_q    <= gnt_op;
          key_q   <= gnt_key;
          rr      <= ~gnt_port;
          lat_cnt <= '0;
        end
        S_LOOKUP: lat_cnt <= lat_cnt + 1'b1;
        S_DECIDE: begin
          if (!op_q) begin
            if (cam_match) begin
              rsp_addr_q <= cam_match_addr; rsp_status_q <= 2'b01;
            end else if (has_free) begin
              waddr_q    <= free_addr;
              rsp_addr_q <= free_addr;     rsp_status_q <= 2'b00;
            end else begin
              rsp_addr_q <= '0;            rsp_status_q <= 2'b10;
            end
          end else begin
            if (cam_match) begin
              waddr_q    <= cam_match_addr;
              rsp_addr_q <= cam_match_addr; rsp_status_q <= 2'b01;
            end else begin
              rsp_addr_q <= '0;             rsp_status_q <= 2'b11;
            end
          end
        end
        S_WRITE: begin
          bitmap[waddr_q] <= ~op_q;
          wait_first      <= 1'b1;
        end
        S_WAIT: wait_first <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rsp_valid        = (state == S_RESP);
  assign rsp_port         = port_q;
  assign rsp_addr         = rsp_addr_q;
  assign rsp_status       = rsp_status_q;
  assign cam_write_enable = (state == S_WRITE);
  assign cam_write_addr   = cam_write_enable ? waddr_q : '0;
  assign cam_write_data   = cam_write_enable ? key_q   : '0;
  assign cam_write_delete = cam_write_enable && op_q;
  // Key is presented from the grant cycle so the CAM result is ready at DECIDE
  assign cam_compare_data = gnt_vld ? gnt_key :
                            (state == S_LOOKUP || state == S_DECIDE) ? key_q : '0;
  assign busy             = (state != S_IDLE);

`ifdef CAM_CTRL_OCCUPANCY_EN
  always_ff @(posedge clk) begin
    if (rst)                     used_count <= '0;
    else if (state == S_WRITE)   used_count <= op_q ? used_count - 1'b1 : used_count + 1'b1;
  end
  assign full = (used_count == (ADDR_WIDTH+1)'(SLOTS));
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// Scoreboard bench for cam_ctrl with a behavioural CAM (registered match, registered busy).
module tb_cam_ctrl;
  localparam int DW = 64, AW = 5, N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, init_hold;
  logic req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
  logic [DW-1:0] req0_key, req1_key;
  logic rsp_valid, rsp_port;
  logic [AW-1:0] rsp_addr;
  logic [1:0] rsp_status;
  logic [AW-1:0] cam_write_addr, cam_match_addr;
  logic [DW-1:0] cam_write_data, cam_compare_data;
  logic cam_write_delete, cam_write_enable, cam_write_busy, cam_match, busy;

  cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOOKUP_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_addr(rsp_addr), .rsp_status(rsp_status),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
    .cam_match_addr(cam_match_addr), .cam_match(cam_match), .busy(busy)
  );

  // Behavioural CAM: one-cycle compare latency, busy for 3 cycles after each write
  logic [DW-1:0] cam_key [N];
  logic [N-1:0]  cam_vld;
  int            bcnt;
  logic          m_q;
  logic [AW-1:0] ma_q;
  always @(posedge clk) begin
    if (rst) begin
      cam_vld <= '0; bcnt <= 0; m_q <= 1'b0; ma_q <= '0;
    end else begin
      m_q <= 1'b0; ma_q <= '0;
      for (int i = N-1; i >= 0; i--)
        if (cam_vld[i] && cam_key[i] == cam_compare_data) begin m_q <= 1'b1; ma_q <= AW'(i); end
      if (cam_write_enable) begin
        if (cam_write_delete) cam_vld[cam_write_addr] <= 1'b0;
        else begin cam_key[cam_write_addr] <= cam_write_data; cam_vld[cam_write_addr] <= 1'b1; end
        bcnt <= 3;
      end else if (bcnt > 0) bcnt <= bcnt - 1;
    end
  end
  assign cam_match      = m_q;
  assign cam_match_addr = ma_q;
  assign cam_write_busy = init_hold || (bcnt != 0);

  typedef struct { logic port; logic [AW-1:0] addr; logic [1:0] st; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, rsp_cnt = 0, we_cnt = 0;
  logic last_del;
  logic [AW-1:0] last_waddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cam_write_enable) begin
        we_cnt++; last_del = cam_write_delete; last_waddr = cam_write_addr;
      end
      if (rsp_valid) begin
        exp_t e;
        rsp_cnt++;
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got port %0d addr %0d status %0d expected none",
                   rsp_port, rsp_addr, rsp_status);
        end else begin
          e = q.pop_front();
          chk("rsp_port", rsp_port, e.port);
          chk("rsp_addr", rsp_addr, e.addr);
          chk("rsp_status", rsp_status, e.st);
        end
      end
    end
  end

  task automatic drive(input bit p, input bit op, input logic [DW-1:0] key);
    int n = 0;
    bit got = 0;
    if (p) begin req1_valid = 1; req1_op = op; req1_key = key; end
    else   begin req0_valid = 1; req0_op = op; req0_key = key; end
    while (!got && n < 300) begin
      @(negedge clk); got = p ? req1_ready : req0_ready;
      @(posedge clk); #1; n++;
    end
    if (!got) begin tests++; fails++; $display("FAIL req_timeout: port %0d not accepted, expected accept", p); end
    if (p) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_rsp(input int target);
    int c = 0;
    while (rsp_cnt < target && c < 300) begin @(posedge clk); #1; c++; end
    if (rsp_cnt < target) begin tests++; fails++; $display("FAIL rsp_timeout: got %0d rsps expected %0d", rsp_cnt, target); end
  endtask

  task automatic op1(input bit p, input bit op, input logic [DW-1:0] key,
                     input logic [AW-1:0] ea, input logic [1:0] es);
    int target;
    target = rsp_cnt + 1;
    q.push_back('{p, ea, es});
    drive(p, op, key);
    wait_rsp(target);
  endtask

  initial begin
    int w0, r0, c;
    rst = 1; init_hold = 1;
    req0_valid = 1; req0_op = 0; req0_key = 64'h1234;
    req1_valid = 0; req1_op = 0; req1_key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_we", cam_write_enable, 0);
    chk("rst_ready", req0_ready, 0);
    chk("rst_cmp", cam_compare_data, 0);
    req0_valid = 0;
    @(posedge clk); #1 rst = 0;
    repeat (511) @(posedge clk);
    @(negedge clk);
    chk("init_busy_held", busy, 1);
    init_hold = 0;
    c = 0;
    while (busy && c < 20) begin @(negedge clk); c++; end
    chk("init_to_idle", busy, 0);
    @(posedge clk); #1;

    // First insert, then duplicate insert
    w0 = we_cnt;
    op1(0, 0, 64'h1234, 0, 2'b00);
    chk("ins_we_cnt", we_cnt, w0 + 1);
    chk("ins_we_del", last_del, 0);
    chk("ins_we_addr", last_waddr, 0);
    w0 = we_cnt;
    op1(0, 0, 64'h1234, 0, 2'b01);
    chk("dup_no_write", we_cnt, w0);

    // Fill the table, then overflow
    for (int i = 1; i < N; i++) op1(i[0], 0, 64'h1000 + i, AW'(i), 2'b00);
    w0 = we_cnt;
    op1(0, 0, 64'h9999, 0, 2'b10);
    chk("full_no_write", we_cnt, w0);

    // Delete, delete again, slot reuse
    w0 = we_cnt;
    op1(0, 1, 64'h1234, 0, 2'b01);
    chk("del_we_cnt", we_cnt, w0 + 1);
    chk("del_we_del", last_del, 1);
    chk("del_we_addr", last_waddr, 0);
    w0 = we_cnt;
    op1(1, 1, 64'h1234, 0, 2'b11);
    chk("del_miss_no_write", we_cnt, w0);
    op1(0, 0, 64'h5555, 0, 2'b00);

    // Reset while waiting on the CAM write
    r0 = rsp_cnt;
    drive(0, 1, 64'h1001);
    c = 0;
    while (!cam_write_enable && c < 50) begin @(negedge clk); c++; end
    chk("rstwait_we_seen", cam_write_enable, 1);
    @(posedge clk); #1;
    rst = 1; init_hold = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rstwait_busy", busy, 1);
    repeat (5) @(posedge clk);
    #1 init_hold = 0;
    c = 0;
    while (busy && c < 20) begin @(negedge clk); c++; end
    chk("rstwait_idle", busy, 0);
    chk("rstwait_no_rsp", rsp_cnt, r0);
    @(posedge clk); #1;
    op1(1, 0, 64'h7777, 0, 2'b00);

    // Both ports contending: grants alternate starting with port 0
    r0 = rsp_cnt;
    for (int i = 0; i < 4; i++) begin
      q.push_back('{1'b0, AW'(1 + 2*i), 2'b00});
      q.push_back('{1'b1, AW'(2 + 2*i), 2'b00});
    end
    fork
      begin for (int i = 0; i < 4; i++) drive(0, 0, 64'h100 + i); end
      begin for (int j = 0; j < 4; j++) drive(1, 0, 64'h200 + j); end
    join
    wait_rsp(r0 + 8);
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
Command sequencer and two-port arbiter in front of the block-RAM CAM (write port plus compare port). It accepts insert and delete-by-key requests from two requesters and round-robin arbitrates between them. Each request runs as a lookup, a decision, an optional CAM write, and a wait for the CAM to go idle. The block tracks slot occupancy in a valid bitmap, allocates the lowest free slot on insert, and returns one response per request.

Parameters:
DATA_WIDTH, 64, key width; equals CAM DATA_WIDTH
ADDR_WIDTH, 5, CAM address width; slot count = 2**ADDR_WIDTH
LOOKUP_LATENCY, 1, cycles from cam_compare_data change to valid cam_match/cam_match_addr

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_op  in  1  0=insert, 1=delete
req0_key  in  DATA_WIDTH  port 0 key
req1_valid  in  1  port 1 request valid
req1_ready  out  1  port 1 request accepted this cycle
req1_op  in  1  0=insert, 1=delete
req1_key  in  DATA_WIDTH  port 1 key
rsp_valid  out  1  one-cycle response pulse
rsp_port  out  1  port that issued the request
rsp_addr  out  ADDR_WIDTH  slot used, found or freed
rsp_status  out  2  00 inserted-new, 01 already-present/deleted, 10 full, 11 not-found
cam_write_addr  out  ADDR_WIDTH  to CAM
cam_write_data  out  DATA_WIDTH  to CAM
cam_write_delete  out  1  to CAM
cam_write_enable  out  1  to CAM
cam_write_busy  in  1  from CAM
cam_compare_data  out  DATA_WIDTH  to CAM
cam_match_addr  in  ADDR_WIDTH  from CAM
cam_match  in  1  from CAM
busy  out  1  high whenever the block is not in IDLE

Behaviour:
- Reset (rst=1 at a clk edge) state after the edge:
  - state=INIT; valid bitmap all 0; rr pointer=0.
  - All outputs 0 except busy=1.
  - rst mid-operation abandons the op with no response. A CAM write already issued completes inside the CAM; the bitmap is cleared anyway because the CAM also reinitialises on rst.
- INIT: wait until cam_write_busy=0 (CAM zeroing), then go to IDLE.
- IDLE: reqN_ready is combinational = (state==IDLE) & reqN_valid & granted.
  - Only one port is granted per cycle.
  - If both ports are valid, grant the port != rr pointer's last winner. The pointer updates on each grant; after reset, port 0 wins a tie.
  - On grant, latch port, op and key, then go to LOOKUP.
- LOOKUP: drive cam_compare_data=latched key (held from the grant cycle through DECIDE). Count LOOKUP_LATENCY cycles, then go to DECIDE.
- DECIDE: sample cam_match/cam_match_addr.
  - Insert, match: respond status 01, addr=match_addr, no write.
  - Insert, no match, free slot exists: pick the lowest-index clear bitmap bit, go to WRITE (set).
  - Insert, no match, bitmap full: respond status 10, addr=0.
  - Delete, match: go to WRITE (delete) with addr=match_addr.
  - Delete, no match: respond status 11, addr=0.
- WRITE: cam_write_enable=1 for exactly one cycle, with addr, data=key and delete=op. Update the bitmap bit in the same cycle. Go to WAIT.
- WAIT: ignore cam_write_busy on the first cycle (CAM busy is registered). Thereafter leave when cam_write_busy=0. Respond with status 00 (insert) or 01 (delete).
- RESP: rsp_valid=1 for one cycle with rsp_* stable, then return to IDLE.
  - Minimum spacing between grants is 4 cycles for LOOKUP_LATENCY=1 (IDLE grant, LOOKUP, DECIDE, RESP), plus the write path when a write occurs.
- cam_write_* outputs are 0 outside WRITE, except that cam_write_addr/cam_write_data may hold their last value.
- Requests are never dropped; valid with !ready holds off the requester. Keys and op must be stable until ready.

Optional Feature:
CAM_CTRL_OCCUPANCY_EN
- Defined: adds output used_count [ADDR_WIDTH:0], the popcount of the bitmap, registered.
  - Reset value 0.
  - +1 on an insert write, -1 on a delete write, updated in the WRITE cycle.
  - Adds output full = (used_count == 2**ADDR_WIDTH).
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Release rst and hold the CAM busy 512 cycles -> busy stays 1 until cam_write_busy falls, then IDLE. Insert key 0x1234 on port 0 -> status 00, addr 0, one write_enable pulse, delete=0.
- Insert 0x1234 again -> status 01, addr 0, no write_enable.
- Insert 32 distinct keys (ADDR_WIDTH=5), then a 33rd -> the first 32 get addrs 0..31 with status 00, the 33rd gets status 10, no write.
- Delete 0x1234 -> status 01, addr 0, write_enable with delete=1. Delete it again -> status 11. Next new insert -> addr 0 reused.
- Both ports valid continuously with 4 inserts each -> grants alternate 0,1,0,1..., and rsp_port matches the grant order.
- Assert rst during WAIT -> no rsp_valid, bitmap cleared, state INIT. A subsequent insert gets addr 0.
